mpu_load_sequencer: RTL and testbench

Controller that sequences a matrix LOAD into the MPU. Accepts a command (dimensions, source memory base, destination matrix register) and reads elements row-major from a single-port source memory. Streams elements to the MPU over a valid/ack handshake while holding the MPU enable and configuration stable. Sits between the top-level command issuer and the MPU. Frees the testbench and top level from per-element handshaking.

---
 rtl/mpu_load_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_mpu_load_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_load_sequencer.sv
// rtl/mpu_load_sequencer.sv - row-major matrix LOAD sequencer feeding the MPU (optional macro: MPU_LOAD_TIMEOUT_EN)
module mpu_load_sequencer #(
  parameter int FP              = 32,
  parameter int M               = 2,
  parameter int N               = 2,
  parameter int MBITS           = $clog2(M),
  parameter int NBITS           = $clog2(N),
  parameter int MATRIX_REG_SIZE = 4,
  parameter int MEM_AW          = 8,
  parameter int TIMEOUT         = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [MBITS:0]             cmd_m,
  input  logic [NBITS:0]             cmd_n,
  input  logic [MEM_AW-1:0]          cmd_base,
  input  logic [MATRIX_REG_SIZE-1:0] cmd_reg,
  output logic                       mem_rd_en,
  output logic [MEM_AW-1:0]          mem_addr,
  input  logic [FP-1:0]              mem_rd_data,
  output logic                       mpu_en,
  output logic [MBITS:0]             mpu_m_size,
  output logic [NBITS:0]             mpu_n_size,
  output logic [MATRIX_REG_SIZE-1:0] mpu_reg_addr,
  output logic [FP-1:0]              mpu_element,
  output logic                       mpu_elem_valid,
  input  logic                       mpu_ack,
  input  logic                       mpu_error,
  output logic                       done,
  output logic                       error,
  output logic                       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPT, S_PRESENT, S_DONE, S_ERR
  } state_t;

  // Element index / count width: large enough for (2^(MBITS+1)-1)*(2^(NBITS+1)-1)
  localparam int TW = MBITS + NBITS + 2;
  localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
  localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);

  state_t                     state_q;
  logic                       cmd_ready_q, mem_rd_en_q, mpu_en_q, valid_q;
  logic                       done_q, error_q, busy_q;
  logic [MEM_AW-1:0]          mem_addr_q;
  logic [MBITS:0]             m_q;
  logic [NBITS:0]             n_q;
  logic [MATRIX_REG_SIZE-1:0] reg_q;
  logic [FP-1:0]              elem_q;
  logic [TW-1:0]              idx_q, total_q;
  logic                       dims_bad;
  logic                       tmo_hit;

  assign dims_bad = (cmd_m == '0) || (cmd_m > M_MAX) || (cmd_n == '0) || (cmd_n > N_MAX);

`ifdef MPU_LOAD_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] tmo_q;

  // Ack-wait counter: zero outside PRESENT so every PRESENT entry starts fresh
  always_ff @(posedge clk) begin
    if (!rst || state_q != S_PRESENT) tmo_q <= '0;
    else                              tmo_q <= tmo_q + TCW'(1);
  end

  assign tmo_hit = (tmo_q == TCW'(TIMEOUT - 1));
`else
  // Without the timeout PRESENT waits forever; this term is constant false
  assign tmo_hit = (TIMEOUT < 0);
`endif

  // Sequencer FSM: all outputs are registered and set on the transition into a state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      mem_rd_en_q <= 1'b0;
      mpu_en_q    <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      m_q         <= '0;
      n_q         <= '0;
      reg_q       <= '0;
      elem_q      <= '0;
      idx_q       <= '0;
      total_q     <= '0;
    end else begin
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      mem_rd_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            m_q         <= cmd_m;
            n_q         <= cmd_n;
            reg_q       <= cmd_reg;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (dims_bad) begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end else begin
              state_q     <= S_READ;
              mpu_en_q    <= 1'b1;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= cmd_base;
              idx_q       <= '0;
              total_q     <= TW'(cmd_m) * TW'(cmd_n);
            end
          end
        end
        S_READ: begin
          if (mpu_error) begin
            state_q  <= S_ERR;
            error_q  <= 1'b1;
            mpu_en_q <= 1'b0;
          end else begin
            state_q <= S_CAPT;
          end
        end
        S_CAPT: begin
          if (mpu_error) begin
            state_q  <= S_ERR;
            error_q  <= 1'b1;
            mpu_en_q <= 1'b0;
          end else begin
            state_q <= S_PRESENT;
            elem_q  <= mem_rd_data;
            valid_q <= 1'b1;
          end
        end
        S_PRESENT: begin
          // A fault wins over an ack arriving in the same cycle
          if (mpu_error || (!mpu_ack && tmo_hit)) begin
            state_q  <= S_ERR;
            error_q  <= 1'b1;
            mpu_en_q <= 1'b0;
            valid_q  <= 1'b0;
          end else if (mpu_ack) begin
            valid_q <= 1'b0;
            if (idx_q == total_q - TW'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_READ;
              idx_q       <= idx_q + TW'(1);
              mem_addr_q  <= mem_addr_q + MEM_AW'(1);
              mem_rd_en_q <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          state_q     <= S_IDLE;
          mpu_en_q    <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign mem_rd_en      = mem_rd_en_q;
  assign mem_addr       = mem_addr_q;
  assign mpu_en         = mpu_en_q;
  assign mpu_m_size     = m_q;
  assign mpu_n_size     = n_q;
  assign mpu_reg_addr   = reg_q;
  assign mpu_element    = elem_q;
  assign mpu_elem_valid = valid_q;
  assign done           = done_q;
  assign error          = error_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mpu_load_sequencer.sv
// tb/tb_mpu_load_sequencer.sv - scoreboard bench for mpu_load_sequencer
module tb_mpu_load_sequencer;
  localparam int FP = 32, M = 2, N = 2, MBITS = $clog2(M), NBITS = $clog2(N);
  localparam int MRS = 4, AW = 8, TMO = 64;

  logic clk = 1'b0, rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [MBITS:0] cmd_m = '0;
  logic [NBITS:0] cmd_n = '0;
  logic [AW-1:0] cmd_base = '0;
  logic [MRS-1:0] cmd_reg = '0;
  logic mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [FP-1:0] mem_rd_data = '0;
  logic mpu_en, mpu_elem_valid, done, error, busy;
  logic [MBITS:0] mpu_m_size;
  logic [NBITS:0] mpu_n_size;
  logic [MRS-1:0] mpu_reg_addr;
  logic [FP-1:0] mpu_element;
  logic mpu_ack = 1'b0, mpu_error = 1'b0;

  always #5 clk = ~clk;

  mpu_load_sequencer #(.FP(FP), .M(M), .N(N), .MBITS(MBITS), .NBITS(NBITS),
                       .MATRIX_REG_SIZE(MRS), .MEM_AW(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_base(cmd_base), .cmd_reg(cmd_reg),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mpu_en(mpu_en), .mpu_m_size(mpu_m_size), .mpu_n_size(mpu_n_size),
    .mpu_reg_addr(mpu_reg_addr), .mpu_element(mpu_element),
    .mpu_elem_valid(mpu_elem_valid), .mpu_ack(mpu_ack), .mpu_error(mpu_error),
    .done(done), .error(error), .busy(busy));

  typedef struct {
    logic [FP-1:0]  data;
    logic [MRS-1:0] r;
    logic [MBITS:0] m;
    logic [NBITS:0] n;
  } elem_t;
  typedef struct {
    bit is_done;
    int exp_cyc;
  } out_t;

  logic [AW-1:0] addr_q[$];
  elem_t         elem_q[$];
  out_t          out_q[$];
  logic [FP-1:0] mem[256];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int ack_mode = 0, err_elem = -1, elem_idx = 0, wait_cnt = 0, want = 0;
  bit forbid_en = 1'b0;

  // Single-port source memory, one cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input int idx);
    case (ack_mode)
      0:       return $urandom_range(0, 3);
      1:       return (idx == 2) ? 5 : 0;
      3:       return 1000000;
      default: return 0;
    endcase
  endfunction

  // Read-address monitor
  initial forever begin
    @(negedge clk);
    if (rst && mem_rd_en) begin
      if (addr_q.size() == 0) chk("addr_unexpected_read", {56'd0, mem_addr}, 64'hFFFF);
      else chk("read_addr", {56'd0, mem_addr}, {56'd0, addr_q.pop_front()});
      chk("en_during_read", {63'd0, mpu_en}, 64'd1);
    end
  end

  // Element checker and MPU responder: data must match and stay put until acked
  initial forever begin
    @(negedge clk);
    mpu_ack = 1'b0;
    mpu_error = 1'b0;
    if (rst && mpu_elem_valid) begin
      if (elem_q.size() == 0) chk("elem_unexpected", {32'd0, mpu_element}, 64'hFFFF_FFFF_FFFF);
      else begin
        chk("elem_data", {32'd0, mpu_element}, {32'd0, elem_q[0].data});
        chk("reg_addr", {60'd0, mpu_reg_addr}, {60'd0, elem_q[0].r});
        chk("m_size", {62'd0, mpu_m_size}, {62'd0, elem_q[0].m});
        chk("n_size", {62'd0, mpu_n_size}, {62'd0, elem_q[0].n});
      end
      chk("en_during_valid", {63'd0, mpu_en}, 64'd1);
      if (wait_cnt >= want) begin
        mpu_ack = 1'b1;
        if (elem_idx == err_elem) begin
          mpu_error = 1'b1;
          err_elem = -1;
        end
        if (elem_q.size() != 0) void'(elem_q.pop_front());
        elem_idx++;
        wait_cnt = 0;
        want = pick(elem_idx);
      end else wait_cnt++;
    end
  end

  // Outcome monitor: each done/error cycle consumes exactly one expected outcome
  initial forever begin
    @(negedge clk);
    if (rst && forbid_en) chk("en_forbidden", {63'd0, mpu_en}, 64'd0);
    if (rst && (done || error)) begin
      if (out_q.size() == 0) chk("pulse_unexpected", {62'd0, done, error}, 64'd0);
      else begin
        out_t o;
        o = out_q.pop_front();
        chk("done_pulse", {63'd0, done}, {63'd0, o.is_done});
        chk("error_pulse", {63'd0, error}, {63'd0, !o.is_done});
        chk("en_at_end", {63'd0, mpu_en}, {63'd0, o.is_done});
        chk("busy_at_end", {63'd0, busy}, 64'd1);
        if (o.exp_cyc >= 0) chk("end_cycle", 64'(cyc), 64'(o.exp_cyc));
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_mpu_en"}, {63'd0, mpu_en}, 64'd0);
    chk({tag, "_pulses_rd_valid"}, {60'd0, done, error, mem_rd_en, mpu_elem_valid}, 64'd0);
    chk({tag, "_addr_elem"}, {24'd0, mem_addr, mpu_element}, 64'd0);
    chk({tag, "_cfg"}, {56'd0, mpu_m_size, mpu_n_size, mpu_reg_addr}, 64'd0);
  endtask

  task automatic wait_ready();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 500);
    if (!cmd_ready) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  // stop_at: element index at which the load is cut short (-1 = full load)
  // exp_off: cycles from the accept cycle to the end pulse (-1 = not checked)
  task automatic run_cmd(input int m, input int n, input int base, input int r,
                         input int stop_at, input int exp_off);
    bit bad;
    int cnt, acc, k;
    out_t o;
    elem_t e;
    bad = (m == 0) || (m > M) || (n == 0) || (n > N);
    wait_ready();
    acc = cyc;
    cnt = bad ? 0 : ((stop_at < 0) ? m * n : stop_at + 1);
    for (int i = 0; i < cnt; i++) begin
      addr_q.push_back(AW'((base + i) % 256));
      e.data = mem[(base + i) % 256];
      e.r = MRS'(r);
      e.m = (MBITS+1)'(m);
      e.n = (NBITS+1)'(n);
      elem_q.push_back(e);
    end
    o.is_done = !bad && (stop_at < 0);
    o.exp_cyc = (exp_off < 0) ? -1 : acc + exp_off;
    out_q.push_back(o);
    elem_idx = 0;
    wait_cnt = 0;
    want = pick(0);
    forbid_en = bad;
    cmd_valid = 1'b1;
    cmd_m = (MBITS+1)'(m);
    cmd_n = (NBITS+1)'(n);
    cmd_base = AW'(base);
    cmd_reg = MRS'(r);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_m = (MBITS+1)'($urandom);
    cmd_n = (NBITS+1)'($urandom);
    cmd_base = AW'($urandom);
    cmd_reg = MRS'($urandom);
    k = 0;
    while (out_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (out_q.size() != 0) begin
      chk("outcome_timeout", 64'(out_q.size()), 64'd0);
      out_q.delete();
    end
    chk("reads_left_over", 64'(addr_q.size()), 64'd0);
    addr_q.delete();
    elem_q.delete();
    forbid_en = 1'b0;
    err_elem = -1;
  endtask

  initial begin
    int m, n;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'h3F80_0000;
    mem[8'h11] = 32'h4000_0000;
    mem[8'h12] = 32'h4040_0000;
    mem[8'h13] = 32'h4080_0000;

    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // 2x2 with immediate ack: done lands 12 edges after the accept edge
    ack_mode = 2;
    run_cmd(2, 2, 'h10, 3, -1, 13);
    // ack on element 2 held off for 5 cycles
    ack_mode = 1;
    run_cmd(2, 2, 'h10, 3, -1, -1);
    // address wrap past 0xFF
    ack_mode = 2;
    run_cmd(2, 2, 'hFE, 5, -1, 13);
    // illegal dimensions: error in the cycle after acceptance
    run_cmd(0, 2, 'h40, 1, -1, 1);
    run_cmd(2, N + 1, 'h40, 1, -1, 1);
    // fault together with ack on element 1
    err_elem = 1;
    run_cmd(2, 2, 'h20, 7, 1, -1);

    // reset during CAPT: everything clears and no pulse follows
    wait_ready();
    addr_q.push_back(8'h50);
    cmd_valid = 1'b1; cmd_m = 2'd2; cmd_n = 2'd2; cmd_base = 8'h50; cmd_reg = 4'd9;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("post_mid_reset");
    chk("mid_reset_reads", 64'(addr_q.size()), 64'd0);
    addr_q.delete();

`ifdef MPU_LOAD_TIMEOUT_EN
    // no ack: PRESENT entered 2 edges after accept, error 64 cycles later
    ack_mode = 3;
    run_cmd(1, 2, 'h30, 2, 0, 3 + TMO);
`endif

    ack_mode = 0;
    for (int t = 0; t < 40; t++) begin
      m = $urandom_range(0, 3);
      n = $urandom_range(0, 3);
      run_cmd(m, n, $urandom_range(0, 255), $urandom_range(0, 15), -1,
              (m == 0 || m > M || n == 0 || n > N) ? 1 : -1);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
